fp_mul_normalize: RTL and testbench

- Post-multiply stage that sits directly downstream of the single-precision multiplier datapath.
- Consumes the raw sign, the unnormalised biased exponent sum and the 48-bit mantissa product.
- Performs normalisation, round-to-nearest-even, post-round renormalisation and overflow/underflow detection over a fixed multi-cycle FSM.
- Emits a packed IEEE-754 single with a one-cycle done pulse.

---
 rtl/fp_mul_normalize_pkg.sv | 30 +++
 rtl/fp_mul_normalize_if.sv | 32 +++
 rtl/fp_mul_normalize_rne_round.sv | 22 ++
 rtl/fp_mul_normalize.sv | 137 +++++++++++++
 tb/tb_fp_mul_normalize.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fp_mul_normalize_pkg.sv
// Shared floating-point constants and state/class encodings for the multiplier and adder back ends.
// Pure declarations: no timing or flow control of its own.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int RAWEXP_W = 10;
    localparam int MANT_W   = 2 * (FRAC_W + 1);

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ROUND,
        CHECK,
        SPECIAL,
        DONE
    } norm_state_t;

    typedef enum logic [1:0] {
        FP_NORMAL,
        FP_ZERO,
        FP_INF,
        FP_NAN
    } fp_special_t;

endpackage

// File: rtl/fp_mul_normalize_if.sv
// Request/result bundle between the multiplier datapath and the normalise stage.
// master = upstream producer, slave = fp_mul_normalize.
interface fp_mul_normalize_if #(
    parameter int EXP_W    = 8,
    parameter int FRAC_W   = 23,
    parameter int RAWEXP_W = 10
);
    localparam int MANT_W = 2 * (FRAC_W + 1);

    logic                       norm_start;
    logic                       raw_sign;
    logic signed [RAWEXP_W-1:0] raw_exp;
    logic [MANT_W-1:0]          raw_mant;
    logic [1:0]                 raw_special;

    logic [EXP_W+FRAC_W:0]      norm_result;
    logic                       norm_done;
    logic                       norm_busy;
    logic                       norm_overflow;
    logic                       norm_underflow;
    logic                       norm_inexact;

    modport master (
        output norm_start, raw_sign, raw_exp, raw_mant, raw_special,
        input  norm_result, norm_done, norm_busy, norm_overflow, norm_underflow, norm_inexact
    );

    modport slave (
        input  norm_start, raw_sign, raw_exp, raw_mant, raw_special,
        output norm_result, norm_done, norm_busy, norm_overflow, norm_underflow, norm_inexact
    );
endinterface

// File: rtl/fp_mul_normalize_rne_round.sv
// Round-to-nearest-even on a fraction with guard/round/sticky; purely combinational.
// carry_o means the implicit-one significand rolled over to 2.0 (frac_o is then zero).
module rne_round #(
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              g_i,
    input  logic              r_i,
    input  logic              s_i,
    output logic [FRAC_W-1:0] frac_o,
    output logic              carry_o,
    output logic              inexact_o
);
    logic inc;

    // {1,frac}+inc overflows exactly when frac itself carries out, so the hidden one is implicit.
    always_comb begin
        inc                = g_i & (r_i | s_i | frac_i[0]);
        {carry_o, frac_o}  = {1'b0, frac_i} + {{FRAC_W{1'b0}}, inc};
        inexact_o          = g_i | r_i | s_i;
    end
endmodule

// File: rtl/fp_mul_normalize.sv
// Normalise, round (RNE) and range-check a raw single-precision product; 5-cycle FSM, special operands 3 cycles.
// No backpressure: a start arriving while busy is dropped, results hold until the next capture.
module fp_mul_normalize
    import fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int FRAC_W   = 23,
    parameter int RAWEXP_W = 10
) (
    input logic          clk,
    input logic          n_rst,
    fp_mul_normalize_if.slave bus
);
    localparam int PROD_W = 2 * (FRAC_W + 1);
    localparam logic signed [RAWEXP_W-1:0] EXP_ONE  = RAWEXP_W'(1);
    localparam logic signed [RAWEXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [RAWEXP_W-1:0] EXP_SAT  = RAWEXP_W'(EXP_MAX);

    norm_state_t                state_q, state_d;
    logic                       sign_q;
    logic signed [RAWEXP_W-1:0] exp_q;
    logic [PROD_W-1:0]          mant_q;
    fp_special_t                spec_q;
    logic [FRAC_W-1:0]          frac_q;
    logic                       g_q, r_q, s_q;
    logic [EXP_W+FRAC_W:0]      result_q;
    logic                       done_q, ovf_q, unf_q, inx_q;

    logic [PROD_W-3:0]          shifted;
    logic                       dropped;
    logic [FRAC_W-1:0]          rnd_frac;
    logic                       rnd_carry, rnd_inexact;

    // Hidden one lands on bit 46 after the optional shift; only the bits below it matter.
    always_comb begin
        shifted = mant_q[PROD_W-1] ? mant_q[PROD_W-2:1] : mant_q[PROD_W-3:0];
        dropped = mant_q[PROD_W-1] & mant_q[0];
    end

    rne_round #(.FRAC_W(FRAC_W)) u_round (
        .frac_i    (frac_q),
        .g_i       (g_q),
        .r_i       (r_q),
        .s_i       (s_q),
        .frac_o    (rnd_frac),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.norm_start)
                         state_d = (fp_special_t'(bus.raw_special) != FP_NORMAL) ? SPECIAL : NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = CHECK;
            CHECK:   state_d = DONE;
            SPECIAL: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            spec_q   <= FP_NORMAL;
            frac_q   <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: if (bus.norm_start) begin
                    sign_q <= bus.raw_sign;
                    exp_q  <= bus.raw_exp;
                    mant_q <= bus.raw_mant;
                    spec_q <= fp_special_t'(bus.raw_special);
                    ovf_q  <= 1'b0;
                    unf_q  <= 1'b0;
                    inx_q  <= 1'b0;
                end
                NORM: begin
                    if (mant_q[PROD_W-1]) exp_q <= exp_q + EXP_ONE;
                    frac_q <= shifted[PROD_W-3 -: FRAC_W];
                    g_q    <= shifted[FRAC_W-1];
                    r_q    <= shifted[FRAC_W-2];
                    s_q    <= (|shifted[FRAC_W-3:0]) | dropped;
                end
                ROUND: begin
                    frac_q <= rnd_frac;
                    if (rnd_carry) exp_q <= exp_q + EXP_ONE;
                    inx_q  <= rnd_inexact;
                end
                CHECK: begin
                    if (exp_q >= EXP_SAT) begin
                        result_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        ovf_q    <= 1'b1;
                    end else if (exp_q <= EXP_ZERO) begin
                        result_q <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                        unf_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, exp_q[EXP_W-1:0], frac_q};
                    end
                end
                SPECIAL: begin
                    case (spec_q)
                        FP_ZERO: result_q <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                        FP_INF:  result_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        default: result_q <= QNAN;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.norm_result    = result_q;
    assign bus.norm_done      = done_q;
    assign bus.norm_busy      = (state_q != IDLE);
    assign bus.norm_overflow  = ovf_q;
    assign bus.norm_underflow = unf_q;
    assign bus.norm_inexact   = inx_q;
endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed plus random checks of fp_mul_normalize against an arithmetic rounding model.
module tb_fp_mul_normalize;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    fp_mul_normalize_if bus ();

    fp_mul_normalize dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rounds by comparing the discarded remainder against half an ULP.
    function automatic void model(input logic s, input int e, input logic [47:0] m,
                                  input logic [1:0] sp, output logic [31:0] res,
                                  output logic ov, output logic un, output logic ix);
        longint unsigned mm, kept, rem, half;
        int sh, ee;
        ov = 1'b0; un = 1'b0; ix = 1'b0;
        if (sp == 2'b01) begin res = {s, 31'b0}; return; end
        if (sp == 2'b10) begin res = {s, 8'hFF, 23'b0}; return; end
        if (sp == 2'b11) begin res = 32'h7FC00000; return; end
        mm   = 64'(m);
        sh   = m[47] ? 24 : 23;
        ee   = e + (m[47] ? 1 : 0);
        kept = mm >> sh;
        rem  = mm - (kept << sh);
        half = 64'd1 << (sh - 1);
        ix   = (rem != 0);
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        if (kept == (64'd1 << 24)) begin kept = kept >> 1; ee = ee + 1; end
        if (ee >= 255)     begin res = {s, 8'hFF, 23'b0}; ov = 1'b1; end
        else if (ee <= 0)  begin res = {s, 31'b0};        un = 1'b1; end
        else               res = {s, ee[7:0], kept[22:0]};
    endfunction

    task automatic do_op(input string tag, input logic s, input int e, input logic [47:0] m,
                         input logic [1:0] sp, input bit use_want, input logic [31:0] want);
        logic [31:0] er;
        logic eo, eu, ei;
        int lat;
        model(s, e, m, sp, er, eo, eu, ei);
        @(negedge clk);
        bus.norm_start  = 1'b1;
        bus.raw_sign    = s;
        bus.raw_exp     = e[9:0];
        bus.raw_mant    = m;
        bus.raw_special = sp;
        @(posedge clk); #1;
        bus.norm_start = 1'b0;
        check({tag, ".busy"}, 32'(bus.norm_busy), 32'd1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.norm_done) begin lat = k; break; end
        end
        check({tag, ".latency"}, 32'(lat), (sp != 2'b00) ? 32'd2 : 32'd4);
        check({tag, ".result"}, bus.norm_result, er);
        if (use_want) check({tag, ".plan"}, bus.norm_result, want);
        check({tag, ".flags"}, {29'b0, bus.norm_overflow, bus.norm_underflow, bus.norm_inexact},
              {29'b0, eo, eu, ei});
        check({tag, ".idle"}, 32'(bus.norm_busy), 32'd0);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'(bus.norm_done), 32'd0);
        check({tag, ".hold"}, bus.norm_result, er);
    endtask

    initial begin
        int dones;
        logic [31:0] seen;
        logic [47:0] a, b;
        n_checks = 0;
        n_fail   = 0;
        n_rst           = 1'b1;
        bus.norm_start  = 1'b0;
        bus.raw_sign    = 1'b0;
        bus.raw_exp     = '0;
        bus.raw_mant    = '0;
        bus.raw_special = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.result", bus.norm_result, 32'h0);
        check("rst.outs", {27'b0, bus.norm_done, bus.norm_busy, bus.norm_overflow,
              bus.norm_underflow, bus.norm_inexact}, 32'h0);
        @(negedge clk);
        n_rst = 1'b0;

        do_op("mul15x2",   1'b0, 128, 48'h600000000000, 2'b00, 1'b1, 32'h40400000);
        do_op("mul15x15",  1'b0, 127, 48'h900000000000, 2'b00, 1'b1, 32'h40100000);
        do_op("mul15x15n", 1'b1, 127, 48'h900000000000, 2'b00, 1'b1, 32'hC0100000);
        do_op("rndcarry",  1'b0, 127, 48'h7FFFFFC00000, 2'b00, 1'b1, 32'h40000000);
        do_op("tie_even",  1'b0, 127, 48'h400000400000, 2'b00, 1'b1, 32'h3F800000);
        do_op("tie_odd",   1'b0, 127, 48'h400000C00000, 2'b00, 1'b1, 32'h3F800002);
        do_op("ovf",       1'b0, 254, 48'h900000000000, 2'b00, 1'b1, 32'h7F800000);
        do_op("ovf_neg",   1'b1, 254, 48'h900000000000, 2'b00, 1'b1, 32'hFF800000);
        do_op("unf",       1'b0, -5,  48'h400000000000, 2'b00, 1'b1, 32'h00000000);
        do_op("exp_one",   1'b0, 1,   48'h400000000000, 2'b00, 1'b1, 32'h00800000);
        do_op("zero_neg",  1'b1, 100, 48'h400000000000, 2'b01, 1'b1, 32'h80000000);
        do_op("inf",       1'b0, 100, 48'h400000000000, 2'b10, 1'b1, 32'h7F800000);
        do_op("nan",       1'b1, 100, 48'h400000000000, 2'b11, 1'b1, 32'h7FC00000);

        for (int i = 0; i < 60; i++) begin
            a = 48'($urandom_range(0, 24'h7FFFFF)) | 48'h800000;
            b = 48'($urandom_range(0, 24'h7FFFFF)) | 48'h800000;
            do_op("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 320)) - 20, a * b,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0, 32'h0);
        end

        // A second request while busy must not start another operation.
        @(negedge clk);
        bus.norm_start  = 1'b1;
        bus.raw_sign    = 1'b0;
        bus.raw_exp     = 10'd127;
        bus.raw_mant    = 48'h900000000000;
        bus.raw_special = 2'b00;
        @(posedge clk); #1;
        bus.raw_exp  = 10'd3;
        bus.raw_mant = 48'h400000000000;
        @(posedge clk); #1;
        bus.norm_start = 1'b0;
        dones = 0;
        seen  = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.norm_done) begin dones++; seen = bus.norm_result; end
        end
        check("busy_start.dones", 32'(dones), 32'd1);
        check("busy_start.result", seen, 32'h40100000);

        // Reset in ROUND aborts without a done pulse.
        @(negedge clk);
        bus.norm_start = 1'b1;
        bus.raw_exp    = 10'd128;
        bus.raw_mant   = 48'h600000000000;
        @(posedge clk); #1;
        bus.norm_start = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        #2;
        check("midrst.result", bus.norm_result, 32'h0);
        check("midrst.outs", {27'b0, bus.norm_done, bus.norm_busy, bus.norm_overflow,
              bus.norm_underflow, bus.norm_inexact}, 32'h0);
        @(negedge clk);
        n_rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.norm_done) dones++;
        end
        check("midrst.nodone", 32'(dones), 32'd0);
        do_op("after_rst", 1'b0, 128, 48'h600000000000, 2'b00, 1'b1, 32'h40400000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
